// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: CPU fetch channel, CPU load/store channel and the shared memory port.
// Ports: inst_* (fetch req/resp), data_* (load/store req, load resp), m_* (downstream req/resp).
// master = arbiter view of the bundle; slave = view of the CPU + memory surrounding it.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch channel
  logic                inst_req_valid;
  logic                inst_req_ready;
  logic [ADDR_W-1:0]   inst_addr;
  logic                inst_valid;
  logic                inst_ready;
  logic [DATA_W-1:0]   inst_rdata;
  // load/store channel
  logic                data_mem_read;
  logic                data_mem_write;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_req_ack;
  logic                data_rdata_valid;
  logic                data_rdata_ready;
  logic [DATA_W-1:0]   data_rdata;
  // shared downstream memory port
  logic                m_req_valid;
  logic                m_req_ready;
  logic                m_req_wen;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W/8-1:0] m_wstrb;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_resp_valid;
  logic                m_resp_ready;
  logic [DATA_W-1:0]   m_rdata;

  modport master (
    input  inst_req_valid, inst_addr, inst_ready,
    input  data_mem_read, data_mem_write, data_addr, data_wstrb, data_wdata, data_rdata_ready,
    input  m_req_ready, m_resp_valid, m_rdata,
    output inst_req_ready, inst_valid, inst_rdata,
    output data_req_ack, data_rdata_valid, data_rdata,
    output m_req_valid, m_req_wen, m_addr, m_wstrb, m_wdata, m_resp_ready
  );

  modport slave (
    output inst_req_valid, inst_addr, inst_ready,
    output data_mem_read, data_mem_write, data_addr, data_wstrb, data_wdata, data_rdata_ready,
    output m_req_ready, m_resp_valid, m_rdata,
    input  inst_req_ready, inst_valid, inst_rdata,
    input  data_req_ack, data_rdata_valid, data_rdata,
    input  m_req_valid, m_req_wen, m_addr, m_wstrb, m_wdata, m_resp_ready
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin share of one memory port between CPU fetch and load/store.
// Latency: upstream accept -> downstream request valid next cycle; read data passes through combinationally.
// Backpressure: one transaction outstanding; request held stable until m_req_ready, response waits on owner's ready.
// Ports: clk, rst (sync, active high), bus (cpu_mem_arbiter_if.master), err_timeout (sticky).
module cpu_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  cpu_mem_arbiter_if.master bus,
  output logic              err_timeout
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic       {CH_INST, CH_DATA} chan_t;

  state_t              state_q, state_d;
  // last_grant_q doubles as the owner of the transaction in flight.
  chan_t               last_grant_q;
  logic                lat_wen_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [STRB_W-1:0]   lat_wstrb_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [CNT_W-1:0]    tmo_cnt_q;
  logic                data_pending;
  logic                grant_inst;
  logic                grant_data;

  // A simultaneous read+write is a write; the read is dropped.
  assign data_pending = bus.data_mem_read | bus.data_mem_write;

  always_comb begin
    state_d              = state_q;
    grant_inst           = 1'b0;
    grant_data           = 1'b0;
    bus.inst_req_ready   = 1'b0;
    bus.inst_valid       = 1'b0;
    bus.inst_rdata       = '0;
    bus.data_req_ack     = 1'b0;
    bus.data_rdata_valid = 1'b0;
    bus.data_rdata       = '0;
    bus.m_req_valid      = 1'b0;
    bus.m_req_wen        = 1'b0;
    bus.m_addr           = '0;
    bus.m_wstrb          = '0;
    bus.m_wdata          = '0;
    bus.m_resp_ready     = 1'b0;
    // Everything stays quiet while rst is high so nothing handshakes in the reset cycle.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (bus.inst_req_valid && data_pending) begin
            // Tie: the channel that did not win last time goes first.
            grant_data = (last_grant_q == CH_INST);
            grant_inst = (last_grant_q == CH_DATA);
          end else begin
            grant_inst = bus.inst_req_valid;
            grant_data = data_pending;
          end
          bus.inst_req_ready = grant_inst;
          bus.data_req_ack   = grant_data;
          if (grant_inst || grant_data) state_d = REQ;
        end
        REQ: begin
          bus.m_req_valid = 1'b1;
          bus.m_req_wen   = lat_wen_q;
          bus.m_addr      = lat_addr_q;
          bus.m_wstrb     = lat_wstrb_q;
          bus.m_wdata     = lat_wdata_q;
          if (bus.m_req_ready) state_d = lat_wen_q ? IDLE : RESP;
        end
        RESP: begin
          if (last_grant_q == CH_INST) begin
            bus.inst_valid   = bus.m_resp_valid;
            bus.inst_rdata   = bus.m_rdata;
            bus.m_resp_ready = bus.inst_ready;
          end else begin
            bus.data_rdata_valid = bus.m_resp_valid;
            bus.data_rdata       = bus.m_rdata;
            bus.m_resp_ready     = bus.data_rdata_ready;
          end
          if (bus.m_resp_valid && bus.m_resp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= CH_INST;
      lat_wen_q    <= 1'b0;
      lat_addr_q   <= '0;
      lat_wstrb_q  <= '0;
      lat_wdata_q  <= '0;
      tmo_cnt_q    <= '0;
      err_timeout  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_inst) begin
        last_grant_q <= CH_INST;
        lat_wen_q    <= 1'b0;
        lat_addr_q   <= bus.inst_addr;
        lat_wstrb_q  <= '0;
        lat_wdata_q  <= '0;
        tmo_cnt_q    <= '0;
      end else if (grant_data) begin
        last_grant_q <= CH_DATA;
        lat_wen_q    <= bus.data_mem_write;
        lat_addr_q   <= bus.data_addr;
        lat_wstrb_q  <= bus.data_wstrb;
        lat_wdata_q  <= bus.data_wdata;
        tmo_cnt_q    <= '0;
      end else if (state_q != IDLE) begin
        // Flag only; the transaction keeps running. Counter saturates instead of wrapping.
        if (TIMEOUT_EN && (tmo_cnt_q == CNT_LAST)) err_timeout <= 1'b1;
        if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_timeout;
  int   checks = 0;
  int   errors = 0;

  cpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.inst_req_valid   = 1'b0;
    bus.inst_addr        = '0;
    bus.inst_ready       = 1'b0;
    bus.data_mem_read    = 1'b0;
    bus.data_mem_write   = 1'b0;
    bus.data_addr        = '0;
    bus.data_wstrb       = '0;
    bus.data_wdata       = '0;
    bus.data_rdata_ready = 1'b0;
    bus.m_req_ready      = 1'b0;
    bus.m_resp_valid     = 1'b0;
    bus.m_rdata          = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.inst_req_valid = 1'b1; bus.data_mem_read = 1'b1; bus.m_resp_valid = 1'b1;
    bus.inst_ready = 1'b1; bus.data_rdata_ready = 1'b1; bus.m_rdata = '1;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if ({bus.inst_req_ready, bus.data_req_ack, bus.m_req_valid, bus.m_resp_ready, bus.inst_valid, bus.data_rdata_valid} !== 6'b0) begin errors++; $display("FAIL reset_valids got %b required 000000", {bus.inst_req_ready, bus.data_req_ack, bus.m_req_valid, bus.m_resp_ready, bus.inst_valid, bus.data_rdata_valid}); end
    checks++; if ({bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata, bus.inst_rdata, bus.data_rdata} !== '0) begin errors++; $display("FAIL reset_data m_addr=%h m_wdata=%h inst_rdata=%h data_rdata=%h required all 0", bus.m_addr, bus.m_wdata, bus.inst_rdata, bus.data_rdata); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", err_timeout); end
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.inst_req_ready, bus.data_req_ack, bus.m_req_valid, bus.m_resp_ready, bus.inst_valid, bus.data_rdata_valid} !== 6'b0) begin errors++; $display("FAIL idle_quiet got %b required 000000", {bus.inst_req_ready, bus.data_req_ack, bus.m_req_valid, bus.m_resp_ready, bus.inst_valid, bus.data_rdata_valid}); end
    next_cycle();
  endtask

  task automatic test_fetch_read();
    do_reset();
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0040; bus.m_req_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.inst_req_ready, bus.data_req_ack, bus.m_req_valid} !== 3'b100) begin errors++; $display("FAIL fetch_accept {ready,ack,m_valid} got %b required 100", {bus.inst_req_ready, bus.data_req_ack, bus.m_req_valid}); end
    next_cycle();
    bus.inst_req_valid = 1'b0; bus.inst_addr = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({bus.inst_req_ready, bus.m_req_valid, bus.m_req_wen} !== 3'b010) begin errors++; $display("FAIL fetch_req {ready,m_valid,wen} got %b required 010", {bus.inst_req_ready, bus.m_req_valid, bus.m_req_wen}); end
    checks++; if ({bus.m_addr, bus.m_wstrb} !== {32'h0000_0040, 4'h0}) begin errors++; $display("FAIL fetch_req_fields addr=%h wstrb=%h required 00000040/0", bus.m_addr, bus.m_wstrb); end
    next_cycle();
    bus.m_req_ready = 1'b0; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.inst_valid, bus.m_resp_ready, bus.m_req_valid} !== 3'b010) begin errors++; $display("FAIL fetch_wait {inst_valid,m_resp_ready,m_valid} got %b required 010", {bus.inst_valid, bus.m_resp_ready, bus.m_req_valid}); end
    next_cycle();
    bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h2402_0001;
    @(negedge clk);
    checks++; if ({bus.inst_valid, bus.data_rdata_valid} !== 2'b10) begin errors++; $display("FAIL fetch_resp_valid {inst,data} got %b required 10", {bus.inst_valid, bus.data_rdata_valid}); end
    checks++; if (bus.inst_rdata !== 32'h2402_0001) begin errors++; $display("FAIL fetch_rdata got %h required 24020001", bus.inst_rdata); end
    next_cycle();
    bus.m_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.inst_valid, bus.m_req_valid, bus.m_resp_ready} !== 3'b000) begin errors++; $display("FAIL fetch_done got %b required 000", {bus.inst_valid, bus.m_req_valid, bus.m_resp_ready}); end
    next_cycle();
  endtask

  task automatic test_store();
    do_reset();
    bus.data_mem_write = 1'b1; bus.data_addr = 32'h0000_000C; bus.data_wstrb = 4'hF; bus.data_wdata = 32'h0;
    bus.m_req_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.data_req_ack, bus.inst_req_ready} !== 2'b10) begin errors++; $display("FAIL store_ack {ack,inst_ready} got %b required 10", {bus.data_req_ack, bus.inst_req_ready}); end
    next_cycle();
    bus.data_mem_write = 1'b0; bus.data_addr = 32'h5555_5555; bus.data_wdata = 32'hAAAA_AAAA;
    @(negedge clk);
    checks++; if ({bus.m_req_valid, bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata} !== {1'b1, 1'b1, 32'h0000_000C, 4'hF, 32'h0}) begin errors++; $display("FAIL store_req valid=%b wen=%b addr=%h wstrb=%h wdata=%h required 1/1/0000000c/f/00000000", bus.m_req_valid, bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata); end
    next_cycle();
    // Back in IDLE straight away: a fresh fetch must be accepted, no response phase.
    bus.m_req_ready = 1'b0; bus.inst_req_valid = 1'b1; bus.m_resp_valid = 1'b1; bus.data_rdata_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.inst_req_ready, bus.m_req_valid, bus.m_resp_ready, bus.data_rdata_valid} !== 4'b1000) begin errors++; $display("FAIL store_no_resp {inst_ready,m_valid,m_resp_ready,data_valid} got %b required 1000", {bus.inst_req_ready, bus.m_req_valid, bus.m_resp_ready, bus.data_rdata_valid}); end
    next_cycle();
  endtask

  task automatic test_tie_alternation();
    int n;
    bit seq [4];
    n = 0;
    do_reset();
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h100; bus.data_mem_read = 1'b1; bus.data_addr = 32'h200;
    bus.m_req_ready = 1'b1; bus.m_resp_valid = 1'b1; bus.inst_ready = 1'b1; bus.data_rdata_ready = 1'b1;
    for (int cyc = 0; cyc < 24 && n < 4; cyc++) begin
      @(negedge clk);
      checks++; if (bus.data_req_ack && bus.inst_req_ready) begin errors++; $display("FAIL tie_both_granted cycle %0d got 11 required one-hot", cyc); end
      if (bus.data_req_ack) begin seq[n] = 1'b1; n++; end
      else if (bus.inst_req_ready) begin seq[n] = 1'b0; n++; end
      next_cycle();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL tie_grant_count got %0d required 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (seq[i] !== ((i % 2) == 0)) begin errors++; $display("FAIL tie_order grant %0d got data=%b required data=%b", i, seq[i], ((i % 2) == 0)); end
    end
  endtask

  task automatic test_backpressure();
    int deliv;
    deliv = 0;
    do_reset();
    bus.data_mem_read = 1'b1; bus.data_addr = 32'h1234_5678; bus.data_wstrb = 4'hA; bus.data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.data_req_ack !== 1'b1) begin errors++; $display("FAIL bp_ack got %b required 1", bus.data_req_ack); end
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      bus.m_req_ready = (i == 5);
      @(negedge clk);
      checks++; if ({bus.m_req_valid, bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata} !== {1'b1, 1'b0, 32'h1234_5678, 4'hA, 32'hDEAD_BEEF}) begin errors++; $display("FAIL bp_req_stable cycle %0d valid=%b wen=%b addr=%h wstrb=%h wdata=%h required 1/0/12345678/a/deadbeef", i, bus.m_req_valid, bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata); end
      next_cycle();
    end
    bus.m_req_ready = 1'b0; bus.m_resp_valid = 1'b1; bus.m_rdata = 32'hCAFE_0001;
    for (int i = 0; i < 5; i++) begin
      bus.data_rdata_ready = (i >= 3);
      @(negedge clk);
      if (bus.data_rdata_valid && bus.data_rdata_ready) deliv++;
      if (i < 4) begin
        checks++; if ({bus.data_rdata_valid, bus.inst_valid, bus.m_resp_ready} !== {1'b1, 1'b0, (i == 3)}) begin errors++; $display("FAIL bp_resp cycle %0d {data_valid,inst_valid,m_resp_ready} got %b required %b", i, {bus.data_rdata_valid, bus.inst_valid, bus.m_resp_ready}, {1'b1, 1'b0, (i == 3)}); end
        checks++; if (bus.data_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL bp_rdata cycle %0d got %h required cafe0001", i, bus.data_rdata); end
      end else begin
        checks++; if ({bus.data_rdata_valid, bus.m_resp_ready} !== 2'b00) begin errors++; $display("FAIL bp_after_resp {data_valid,m_resp_ready} got %b required 00", {bus.data_rdata_valid, bus.m_resp_ready}); end
      end
      next_cycle();
    end
    checks++; if (deliv != 1) begin errors++; $display("FAIL bp_deliveries got %0d required 1", deliv); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h80;
    @(negedge clk);
    checks++; if (bus.inst_req_ready !== 1'b1) begin errors++; $display("FAIL tmo_accept got %b required 1", bus.inst_req_ready); end
    next_cycle();
    bus.inst_req_valid = 1'b0;
    // Index k = k-th cycle since REQ entry.
    for (int k = 0; k <= TO; k++) begin
      @(negedge clk);
      checks++; if (err_timeout !== (k == TO)) begin errors++; $display("FAIL tmo_rise k=%0d got %b required %b", k, err_timeout, (k == TO)); end
      next_cycle();
    end
    bus.m_req_ready = 1'b1;
    next_cycle();
    bus.m_req_ready = 1'b0; bus.m_resp_valid = 1'b1; bus.inst_ready = 1'b1;
    next_cycle();
    idle_inputs();
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if ({err_timeout, bus.m_req_valid} !== 2'b10) begin errors++; $display("FAIL tmo_sticky {err,m_valid} got %b required 10", {err_timeout, bus.m_req_valid}); end
    next_cycle();
    do_reset();
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_cleared got %b required 0", err_timeout); end
    next_cycle();
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h300; bus.m_req_ready = 1'b1;
    next_cycle();
    bus.inst_req_valid = 1'b0;
    next_cycle();
    bus.m_req_ready = 1'b0;
    repeat (10) next_cycle();
    @(negedge clk);
    checks++; if ({err_timeout, bus.m_resp_ready} !== 2'b10) begin errors++; $display("FAIL rr_pre {err,m_resp_ready} got %b required 10", {err_timeout, bus.m_resp_ready}); end
    next_cycle();
    rst = 1'b1; bus.m_resp_valid = 1'b1; bus.inst_ready = 1'b1; bus.m_rdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if ({bus.inst_valid, bus.m_resp_ready} !== 2'b00) begin errors++; $display("FAIL rr_during {inst_valid,m_resp_ready} got %b required 00", {bus.inst_valid, bus.m_resp_ready}); end
    next_cycle();
    rst = 1'b0; idle_inputs();
    @(negedge clk);
    checks++; if ({bus.m_req_valid, bus.inst_valid, bus.data_rdata_valid, bus.m_resp_ready, err_timeout} !== 5'b0) begin errors++; $display("FAIL rr_after got %b required 00000", {bus.m_req_valid, bus.inst_valid, bus.data_rdata_valid, bus.m_resp_ready, err_timeout}); end
    next_cycle();
    bus.inst_req_valid = 1'b1; bus.inst_addr = 32'h0000_0044; bus.m_req_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_req_ready !== 1'b1) begin errors++; $display("FAIL rr_refetch_accept got %b required 1", bus.inst_req_ready); end
    next_cycle();
    bus.inst_req_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m_req_valid, bus.m_addr} !== {1'b1, 32'h0000_0044}) begin errors++; $display("FAIL rr_refetch_req valid=%b addr=%h required 1/00000044", bus.m_req_valid, bus.m_addr); end
    next_cycle();
    bus.m_req_ready = 1'b0; bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h0BAD_F00D; bus.inst_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.inst_valid, bus.inst_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL rr_refetch_resp valid=%b rdata=%h required 1/0badf00d", bus.inst_valid, bus.inst_rdata); end
    next_cycle();
  endtask

  // Transaction-level model: one job in flight, tie goes to the channel that did not win last.
  task automatic test_random();
    bit busy, issued, own_data, last_data, errx;
    int age;
    bit gi, gd, ip, dp, e_mrv, e_iv, e_dv, e_mrr;
    logic          cur_wen;
    logic [AW-1:0] cur_addr;
    logic [SW-1:0] cur_wstrb;
    logic [DW-1:0] cur_wdata;
    busy = 0; issued = 0; own_data = 0; last_data = 0; errx = 0; age = 0;
    cur_wen = 0; cur_addr = '0; cur_wstrb = '0; cur_wdata = '0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.inst_req_valid   = ($urandom_range(0, 1) == 1);
      bus.inst_addr        = $urandom;
      bus.data_mem_read    = ($urandom_range(0, 2) == 0);
      bus.data_mem_write   = ($urandom_range(0, 2) == 0);
      bus.data_addr        = $urandom;
      bus.data_wstrb       = SW'($urandom);
      bus.data_wdata       = $urandom;
      bus.m_req_ready      = ($urandom_range(0, 9) < 6);
      bus.m_resp_valid     = ($urandom_range(0, 9) < 6);
      bus.m_rdata          = $urandom;
      bus.inst_ready       = ($urandom_range(0, 3) != 0);
      bus.data_rdata_ready = ($urandom_range(0, 3) != 0);
      ip = bus.inst_req_valid;
      dp = bus.data_mem_read | bus.data_mem_write;
      gi = 0; gd = 0;
      if (!busy) begin
        if (ip && dp) begin gd = !last_data; gi = last_data; end
        else begin gi = ip; gd = dp; end
      end
      e_mrv = busy && !issued;
      e_iv  = busy && issued && !own_data && bus.m_resp_valid;
      e_dv  = busy && issued && own_data && bus.m_resp_valid;
      e_mrr = busy && issued && (own_data ? bus.data_rdata_ready : bus.inst_ready);
      @(negedge clk);
      checks++; if ({bus.inst_req_ready, bus.data_req_ack} !== {gi, gd}) begin errors++; $display("FAIL rnd_grant cyc %0d {inst,data} got %b required %b", cyc, {bus.inst_req_ready, bus.data_req_ack}, {gi, gd}); end
      checks++; if ({bus.m_req_valid, bus.m_resp_ready, bus.inst_valid, bus.data_rdata_valid} !== {e_mrv, e_mrr, e_iv, e_dv}) begin errors++; $display("FAIL rnd_flags cyc %0d {m_valid,m_resp_ready,inst_valid,data_valid} got %b required %b", cyc, {bus.m_req_valid, bus.m_resp_ready, bus.inst_valid, bus.data_rdata_valid}, {e_mrv, e_mrr, e_iv, e_dv}); end
      if (e_mrv) begin
        checks++; if ({bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata} !== {cur_wen, cur_addr, cur_wstrb, cur_wdata}) begin errors++; $display("FAIL rnd_req cyc %0d wen=%b addr=%h wstrb=%h wdata=%h required %b/%h/%h/%h", cyc, bus.m_req_wen, bus.m_addr, bus.m_wstrb, bus.m_wdata, cur_wen, cur_addr, cur_wstrb, cur_wdata); end
      end
      if (e_iv) begin
        checks++; if (bus.inst_rdata !== bus.m_rdata) begin errors++; $display("FAIL rnd_inst_rdata cyc %0d got %h required %h", cyc, bus.inst_rdata, bus.m_rdata); end
      end
      if (e_dv) begin
        checks++; if (bus.data_rdata !== bus.m_rdata) begin errors++; $display("FAIL rnd_data_rdata cyc %0d got %h required %h", cyc, bus.data_rdata, bus.m_rdata); end
      end
      checks++; if (err_timeout !== errx) begin errors++; $display("FAIL rnd_err cyc %0d got %b required %b", cyc, err_timeout, errx); end
      if (gi || gd) begin
        busy = 1; issued = 0; own_data = gd; last_data = gd; age = 0;
        if (gd) begin
          cur_wen = bus.data_mem_write; cur_addr = bus.data_addr; cur_wstrb = bus.data_wstrb; cur_wdata = bus.data_wdata;
        end else begin
          cur_wen = 1'b0; cur_addr = bus.inst_addr; cur_wstrb = '0; cur_wdata = '0;
        end
      end else if (busy) begin
        age++;
        if (age == TO) errx = 1;
        if (!issued) begin
          if (bus.m_req_ready) begin
            if (cur_wen) busy = 0;
            else issued = 1;
          end
        end else if (bus.m_resp_valid && e_mrr) begin
          busy = 0;
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_read();
    test_store();
    test_tie_alternation();
    test_backpressure();
    test_timeout();
    test_reset_in_resp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
